calc_sequencer: RTL and testbench

- Control FSM for the calculator datapath.
- Turns keypad events (hex digit, operator, equals) into single-cycle load/shift strobes for the V1/V2 operand registers.
- Issues start/done handshakes to a multi-cycle arithmetic unit, with an operation timeout.
- Sits between the keypad decoder and the operand-register/arithmetic blocks; owns "flow mode" (whether the next digit overwrites V1 or shifts into it) and operator chaining.

---
 rtl/calc_sequencer_if.sv | 31 +++
 rtl/calc_sequencer.sv | 253 +++++++++++++++++++++++++
 tb/tb_calc_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_sequencer_if.sv
// rtl/calc_sequencer_if.sv - keypad event, operand strobe and arithmetic handshake bundle for calc_sequencer
interface calc_sequencer_if;
    logic       newhex;
    logic [3:0] hexcode;
    logic       newop;
    logic [1:0] opcode;
    logic       eq;
    logic       alu_done;
    logic       v1_shift;
    logic       v1_overwrite;
    logic       v1_load_ans;
    logic       v2_load;
    logic [3:0] hex_out;
    logic [1:0] op_sel;
    logic       alu_start;
    logic       busy;
    logic       err;
    logic       key_drop;

    modport master (
        input  newhex, hexcode, newop, opcode, eq, alu_done,
        output v1_shift, v1_overwrite, v1_load_ans, v2_load, hex_out, op_sel,
        output alu_start, busy, err, key_drop
    );

    modport slave (
        output newhex, hexcode, newop, opcode, eq, alu_done,
        input  v1_shift, v1_overwrite, v1_load_ans, v2_load, hex_out, op_sel,
        input  alu_start, busy, err, key_drop
    );
endinterface

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - calculator control FSM: key events to operand strobes and ALU handshake
// Optional one-deep key buffer during ALU execution when CALC_PENDING_KEY_EN is defined.
module calc_sequencer #(
    parameter int WIDTH       = 16,
    parameter int ALU_TIMEOUT = 64,
    parameter int TMR_W       = 7
) (
    input  logic             clock,
    input  logic             reset,
    calc_sequencer_if.master bus
);
    typedef enum logic [2:0] {S_ENTRY, S_OPWAIT, S_ENTRY2, S_EXEC, S_CHAIN, S_RESULT} state_t;
    typedef enum logic [1:0] {K_NONE, K_HEX, K_OP, K_EQ} key_t;

    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(ALU_TIMEOUT - 1);

    if (WIDTH < 4 || (2 ** TMR_W) <= ALU_TIMEOUT) begin : g_bad_cfg
        $error("calc_sequencer: WIDTH must be >= 4 and 2**TMR_W must exceed ALU_TIMEOUT");
    end

    state_t           state_q, state_d;
    logic             v1_shift_q, v1_shift_d;
    logic             v1_overwrite_q, v1_overwrite_d;
    logic             v1_load_ans_q, v1_load_ans_d;
    logic             v2_load_q, v2_load_d;
    logic [3:0]       hex_out_q, hex_out_d;
    logic [1:0]       op_sel_q, op_sel_d;
    logic             alu_start_q, alu_start_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             key_drop_q, key_drop_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             chain_q, chain_d;
    logic [1:0]       chain_op_q, chain_op_d;
`ifdef CALC_PENDING_KEY_EN
    logic             pend_valid_q, pend_valid_d;
    key_t             pend_kind_q, pend_kind_d;
    logic [3:0]       pend_data_q, pend_data_d;
`endif

    key_t       key_kind;
    logic [3:0] key_data;
    logic       live_any;
    logic       live_drop;
    logic       in_window;

    always_comb begin
        state_d        = state_q;
        v1_shift_d     = 1'b0;
        v1_overwrite_d = 1'b0;
        v1_load_ans_d  = 1'b0;
        v2_load_d      = 1'b0;
        alu_start_d    = 1'b0;
        hex_out_d      = hex_out_q;
        op_sel_d       = op_sel_q;
        busy_d         = busy_q;
        err_d          = err_q;
        timer_d        = timer_q;
        chain_d        = chain_q;
        chain_op_d     = chain_op_q;

        live_any  = bus.newhex | bus.newop | bus.eq;
        live_drop = (bus.eq & (bus.newop | bus.newhex)) | (bus.newop & bus.newhex);
        if (bus.eq) begin
            key_kind = K_EQ;
            key_data = 4'd0;
        end else if (bus.newop) begin
            key_kind = K_OP;
            key_data = {2'b00, bus.opcode};
        end else if (bus.newhex) begin
            key_kind = K_HEX;
            key_data = bus.hexcode;
        end else begin
            key_kind = K_NONE;
            key_data = 4'd0;
        end

        // S_CHAIN is the tail of execution: keys there are treated as if in EXEC
        in_window  = (state_q == S_EXEC) || (state_q == S_CHAIN);
        key_drop_d = in_window ? live_any : live_drop;

`ifdef CALC_PENDING_KEY_EN
        pend_valid_d = pend_valid_q;
        pend_kind_d  = pend_kind_q;
        pend_data_d  = pend_data_q;
        if (in_window && live_any) begin
            if (!pend_valid_q) begin
                pend_valid_d = 1'b1;
                pend_kind_d  = key_kind;
                pend_data_d  = key_data;
                key_drop_d   = live_drop;
            end
        end else if (pend_valid_q && (state_q == S_RESULT || state_q == S_OPWAIT)) begin
            // replayed event takes this cycle's slot; any live key collides with it
            key_kind     = pend_kind_q;
            key_data     = pend_data_q;
            pend_valid_d = 1'b0;
            key_drop_d   = live_any;
        end
`endif

        case (state_q)
            S_ENTRY: begin
                case (key_kind)
                    K_HEX: begin
                        v1_shift_d = 1'b1;
                        hex_out_d  = key_data;
                        err_d      = 1'b0;
                    end
                    K_OP: begin
                        v2_load_d = 1'b1;
                        op_sel_d  = key_data[1:0];
                        state_d   = S_OPWAIT;
                    end
                    K_EQ:    state_d = S_RESULT;
                    default: ;
                endcase
            end
            S_OPWAIT: begin
                case (key_kind)
                    K_HEX: begin
                        v1_overwrite_d = 1'b1;
                        hex_out_d      = key_data;
                        err_d          = 1'b0;
                        state_d        = S_ENTRY2;
                    end
                    K_OP:    op_sel_d = key_data[1:0];
                    default: ;
                endcase
            end
            S_ENTRY2: begin
                case (key_kind)
                    K_HEX: begin
                        v1_shift_d = 1'b1;
                        hex_out_d  = key_data;
                        err_d      = 1'b0;
                    end
                    K_OP: begin
                        alu_start_d = 1'b1;
                        busy_d      = 1'b1;
                        timer_d     = '0;
                        chain_d     = 1'b1;
                        chain_op_d  = key_data[1:0];
                        state_d     = S_EXEC;
                    end
                    K_EQ: begin
                        alu_start_d = 1'b1;
                        busy_d      = 1'b1;
                        timer_d     = '0;
                        state_d     = S_EXEC;
                    end
                    default: ;
                endcase
            end
            S_EXEC: begin
                if (bus.alu_done) begin
                    v1_load_ans_d = 1'b1;
                    busy_d        = 1'b0;
                    state_d       = chain_q ? S_CHAIN : S_RESULT;
                end else if (timer_q == TMO_LAST) begin
                    err_d      = 1'b1;
                    busy_d     = 1'b0;
                    chain_d    = 1'b0;
                    key_drop_d = live_any;
`ifdef CALC_PENDING_KEY_EN
                    pend_valid_d = 1'b0;
`endif
                    state_d    = S_RESULT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_CHAIN: begin
                v2_load_d = 1'b1;
                op_sel_d  = chain_op_q;
                chain_d   = 1'b0;
                state_d   = S_OPWAIT;
            end
            S_RESULT: begin
                case (key_kind)
                    K_HEX: begin
                        v1_overwrite_d = 1'b1;
                        hex_out_d      = key_data;
                        err_d          = 1'b0;
                        state_d        = S_ENTRY;
                    end
                    K_OP: begin
                        v2_load_d = 1'b1;
                        op_sel_d  = key_data[1:0];
                        state_d   = S_OPWAIT;
                    end
                    default: ;
                endcase
            end
            default: state_d = S_ENTRY;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= S_ENTRY;
            v1_shift_q     <= 1'b0;
            v1_overwrite_q <= 1'b0;
            v1_load_ans_q  <= 1'b0;
            v2_load_q      <= 1'b0;
            hex_out_q      <= 4'd0;
            op_sel_q       <= 2'd0;
            alu_start_q    <= 1'b0;
            busy_q         <= 1'b0;
            err_q          <= 1'b0;
            key_drop_q     <= 1'b0;
            timer_q        <= '0;
            chain_q        <= 1'b0;
            chain_op_q     <= 2'd0;
`ifdef CALC_PENDING_KEY_EN
            pend_valid_q   <= 1'b0;
            pend_kind_q    <= K_NONE;
            pend_data_q    <= 4'd0;
`endif
        end else begin
            state_q        <= state_d;
            v1_shift_q     <= v1_shift_d;
            v1_overwrite_q <= v1_overwrite_d;
            v1_load_ans_q  <= v1_load_ans_d;
            v2_load_q      <= v2_load_d;
            hex_out_q      <= hex_out_d;
            op_sel_q       <= op_sel_d;
            alu_start_q    <= alu_start_d;
            busy_q         <= busy_d;
            err_q          <= err_d;
            key_drop_q     <= key_drop_d;
            timer_q        <= timer_d;
            chain_q        <= chain_d;
            chain_op_q     <= chain_op_d;
`ifdef CALC_PENDING_KEY_EN
            pend_valid_q   <= pend_valid_d;
            pend_kind_q    <= pend_kind_d;
            pend_data_q    <= pend_data_d;
`endif
        end
    end

    assign bus.v1_shift     = v1_shift_q;
    assign bus.v1_overwrite = v1_overwrite_q;
    assign bus.v1_load_ans  = v1_load_ans_q;
    assign bus.v2_load      = v2_load_q;
    assign bus.hex_out      = hex_out_q;
    assign bus.op_sel       = op_sel_q;
    assign bus.alu_start    = alu_start_q;
    assign bus.busy         = busy_q;
    assign bus.err          = err_q;
    assign bus.key_drop     = key_drop_q;
endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - scoreboard bench for calc_sequencer with a key-rule reference model
// Model follows CALC_PENDING_KEY_EN the same way the design does.
module tb_calc_sequencer;
    localparam int ALU_TIMEOUT = 64;

    localparam int M_ENTRY  = 0;
    localparam int M_OPWAIT = 1;
    localparam int M_ENTRY2 = 2;
    localparam int M_EXEC   = 3;
    localparam int M_RESULT = 4;
    localparam int K_NONE = 0, K_HEX = 1, K_OP = 2, K_EQ = 3;

    typedef struct packed {
        logic [5:0] strobe;   // key_drop, alu_start, v2_load, v1_load_ans, v1_overwrite, v1_shift
        logic       busy;
        logic       err;
        logic [3:0] hex;
        logic [1:0] op;
    } outv_t;

    typedef struct {
        int    cyc;
        outv_t v;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    calc_sequencer_if bus ();

    calc_sequencer #(.WIDTH(16), .ALU_TIMEOUT(ALU_TIMEOUT), .TMR_W(7)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, expv);
        end
    endfunction

    // Reference model: applies the key rules to one cycle of inputs, yielding next-cycle outputs
    int         m_mode = M_ENTRY;
    bit         m_chain = 0;
    logic [1:0] m_chain_op = 0;
    int         m_age = 0;
    bit         m_defer = 0;
    bit         m_pv = 0;
    int         m_pk = K_NONE;
    logic [3:0] m_pd = 0;
    outv_t      m_out = '0;

    function automatic void model_step(input int c, input bit h, input logic [3:0] hc, input bit o,
                                       input logic [1:0] oc, input bit e, input bit d);
        outv_t      n;
        int         nk;
        int         kind;
        logic [3:0] kd;
        n = m_out;
        n.strobe = '0;
        nk = int'(h) + int'(o) + int'(e);
        kind = e ? K_EQ : (o ? K_OP : (h ? K_HEX : K_NONE));
        kd = e ? 4'd0 : (o ? {2'b00, oc} : (h ? hc : 4'd0));
        if (m_defer || m_mode == M_EXEC) begin
`ifdef CALC_PENDING_KEY_EN
            if (nk > 0) begin
                if (!m_pv) begin
                    m_pv = 1; m_pk = kind; m_pd = kd;
                    n.strobe[5] = (nk > 1);
                end else n.strobe[5] = 1'b1;
            end
`else
            n.strobe[5] = (nk > 0);
`endif
            if (m_defer) begin
                n.strobe[3] = 1'b1; n.op = m_chain_op; m_defer = 0; m_mode = M_OPWAIT;
            end else if (d) begin
                n.strobe[2] = 1'b1; n.busy = 1'b0;
                if (m_chain) begin m_chain = 0; m_defer = 1; end
                else m_mode = M_RESULT;
            end else if (m_age == ALU_TIMEOUT - 1) begin
                n.err = 1'b1; n.busy = 1'b0; m_chain = 0; m_pv = 0;
                n.strobe[5] = (nk > 0);
                m_mode = M_RESULT;
            end else m_age++;
        end else begin
            if (m_pv && (m_mode == M_RESULT || m_mode == M_OPWAIT)) begin
                kind = m_pk; kd = m_pd; m_pv = 0;
                n.strobe[5] = (nk > 0);
            end else n.strobe[5] = (nk > 1);
            if (kind == K_HEX) begin
                n.hex = kd; n.err = 1'b0;
                if (m_mode == M_ENTRY || m_mode == M_ENTRY2) n.strobe[0] = 1'b1;
                else begin
                    n.strobe[1] = 1'b1;
                    m_mode = (m_mode == M_OPWAIT) ? M_ENTRY2 : M_ENTRY;
                end
            end else if (kind == K_OP) begin
                if (m_mode == M_ENTRY2) begin
                    n.strobe[4] = 1'b1; n.busy = 1'b1; m_age = 0;
                    m_chain = 1; m_chain_op = kd[1:0]; m_mode = M_EXEC;
                end else begin
                    if (m_mode != M_OPWAIT) n.strobe[3] = 1'b1;
                    n.op = kd[1:0]; m_mode = M_OPWAIT;
                end
            end else if (kind == K_EQ) begin
                if (m_mode == M_ENTRY) m_mode = M_RESULT;
                else if (m_mode == M_ENTRY2) begin
                    n.strobe[4] = 1'b1; n.busy = 1'b1; m_age = 0; m_mode = M_EXEC;
                end
            end
        end
        if (n.strobe != 6'd0 || n.busy != m_out.busy || n.err != m_out.err)
            exp_q.push_back('{cyc: c + 1, v: n});
        m_out = n;
    endfunction

    function automatic void model_reset(input int c);
        if (m_out.busy || m_out.err) exp_q.push_back('{cyc: c, v: outv_t'(0)});
        m_mode = M_ENTRY; m_chain = 0; m_chain_op = 0; m_age = 0; m_defer = 0;
        m_pv = 0; m_pk = K_NONE; m_pd = 0; m_out = '0;
    endfunction

    function automatic outv_t sample();
        outv_t s;
        s.strobe = {bus.key_drop, bus.alu_start, bus.v2_load, bus.v1_load_ans, bus.v1_overwrite, bus.v1_shift};
        s.busy   = bus.busy;
        s.err    = bus.err;
        s.hex    = bus.hex_out;
        s.op     = bus.op_sel;
        return s;
    endfunction

    outv_t mon_prev = '0;
    outv_t mon_cur;
    exp_t  mon_e;

    always @(negedge clock) begin
        mon_cur = sample();
        if (mon_cur.strobe != 6'd0 || mon_cur.busy != mon_prev.busy || mon_cur.err != mon_prev.err) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output at cycle %0d: got strobes %b busy %0b err %0b, required none",
                         cyc, mon_cur.strobe, mon_cur.busy, mon_cur.err);
            end else begin
                mon_e = exp_q.pop_front();
                chk("event_cycle", cyc, mon_e.cyc);
                chk("strobes", int'(mon_cur.strobe), int'(mon_e.v.strobe));
                chk("busy", int'(mon_cur.busy), int'(mon_e.v.busy));
                chk("err", int'(mon_cur.err), int'(mon_e.v.err));
                chk("hex_out", int'(mon_cur.hex), int'(mon_e.v.hex));
                chk("op_sel", int'(mon_cur.op), int'(mon_e.v.op));
            end
        end
        mon_prev = mon_cur;
    end

    task automatic cycle_in(input bit h, input logic [3:0] hc, input bit o, input logic [1:0] oc,
                            input bit e, input bit d);
        bus.newhex = h; bus.hexcode = hc; bus.newop = o; bus.opcode = oc; bus.eq = e; bus.alu_done = d;
        model_step(cyc, h, hc, o, oc, e, d);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle_in(0, 4'd0, 0, 2'd0, 0, 0);
    endtask
    task automatic hexk(input logic [3:0] v); cycle_in(1, v, 0, 2'd0, 0, 0); endtask
    task automatic opk(input logic [1:0] v);  cycle_in(0, 4'd0, 1, v, 0, 0); endtask
    task automatic eqk();                      cycle_in(0, 4'd0, 0, 2'd0, 1, 0); endtask
    task automatic done();                     cycle_in(0, 4'd0, 0, 2'd0, 0, 1); endtask

    task automatic reset_pulse();
        bus.newhex = 0; bus.newop = 0; bus.eq = 0; bus.alu_done = 0;
        reset = 1'b0;
        model_reset(cyc);
        #1;
        chk("midreset_busy", int'(bus.busy), 0);
        chk("midreset_alu_start", int'(bus.alu_start), 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        bus.newhex = 0; bus.hexcode = 0; bus.newop = 0; bus.opcode = 0; bus.eq = 0; bus.alu_done = 0;
        repeat (3) @(negedge clock);
        chk("rst_v1_shift", int'(bus.v1_shift), 0);
        chk("rst_v1_overwrite", int'(bus.v1_overwrite), 0);
        chk("rst_v1_load_ans", int'(bus.v1_load_ans), 0);
        chk("rst_v2_load", int'(bus.v2_load), 0);
        chk("rst_hex_out", int'(bus.hex_out), 0);
        chk("rst_op_sel", int'(bus.op_sel), 0);
        chk("rst_alu_start", int'(bus.alu_start), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_err", int'(bus.err), 0);
        chk("rst_key_drop", int'(bus.key_drop), 0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // 1 2 + 3 = with done four cycles after start
        hexk(1); idle(1); hexk(2); idle(1); opk(0); idle(1); hexk(3); idle(1);
        eqk(); idle(4); done(); idle(3);
        // chain: 5 + 6 x
        hexk(5); idle(1); opk(0); hexk(6); opk(1); idle(2); done(); idle(3);
        // leave chained OPWAIT via a plain evaluation
        hexk(1); eqk(); idle(2); done(); idle(2);
        // operator replace: 7 + x 2 =
        hexk(7); opk(0); opk(1); hexk(2); eqk(); idle(1); done(); idle(2);
        // timeout, then a hex clears err
        opk(0); hexk(8); eqk(); idle(ALU_TIMEOUT + 3); hexk(3); idle(1);
        // simultaneous keys from ENTRY2, then keys during EXEC
        opk(0); hexk(5); cycle_in(1, 4'hA, 1, 2'd1, 1, 0); idle(1);
        hexk(9); idle(1); hexk(6); idle(1); done(); idle(3);
        // reset in the middle of EXEC
        opk(1); hexk(2); eqk(); idle(3);
        reset_pulse();
        hexk(4); idle(2);

        for (int i = 0; i < 900; i++) begin
            bit         h, o, e, d, hang;
            logic [3:0] hc;
            logic [1:0] oc;
            hang = ((i / 120) % 3) == 2;
            h  = ($urandom_range(0, 99) < 30);
            o  = ($urandom_range(0, 99) < 12);
            e  = ($urandom_range(0, 99) < 12);
            d  = !hang && ($urandom_range(0, 99) < 20);
            hc = 4'($urandom_range(0, 15));
            oc = 2'($urandom_range(0, 3));
            cycle_in(h, hc, o, oc, e, d);
        end
        idle(ALU_TIMEOUT + 6);
        chk("expected_queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
